ps2_paddle_keys: RTL



---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_frame_rx.sv | 101 ++++++++++
 rtl/ps2_paddle_keys.sv | 74 +++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 paddle-key receiver.
//   PS2_EXT / PS2_BRK   : extended and break prefix bytes
//   PS2_UP_DEF / DOWN   : default make codes for the paddle keys
//   rx_state_e          : frame receiver state encoding
package ps2_pkg;

  localparam logic [7:0] PS2_EXT      = 8'hE0;
  localparam logic [7:0] PS2_BRK      = 8'hF0;
  localparam logic [7:0] PS2_UP_DEF   = 8'h75;
  localparam logic [7:0] PS2_DOWN_DEF = 8'h72;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BIT_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  // Odd parity holds when data bits plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [BYTE_W-1:0] data, input logic par);
    return (^data) ^ par;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detector, 11-bit frame
// FSM with inter-edge timeout, parity and stop-bit check.
//   clock, reset_n          : system clock, async active-low reset
//   ps2_clk_in, ps2_dat_in  : raw asynchronous PS/2 pins
//   byte_data, byte_valid   : received byte and one-cycle strobe
//   frame_err               : one-cycle strobe on parity/stop/timeout error
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ps2_clk_in,
  input  logic              ps2_dat_in,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  output logic              frame_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // The FSM leaves on the same edge the counter reaches TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  logic                 clk_s1, clk_s2, clk_prev;
  logic                 dat_s1, dat_s2;
  logic                 fall;
  rx_state_e            state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BYTE_W-1:0]    shift;
  logic                 par;
  logic [CNT_W-1:0]     cnt;

  assign fall = clk_prev & ~clk_s2;

  // Synchronisers and frame FSM; pins reset to the idle-high line level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      clk_prev   <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par        <= 1'b0;
      cnt        <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_s1     <= ps2_clk_in;
      clk_s2     <= clk_s1;
      clk_prev   <= clk_s2;
      dat_s1     <= ps2_dat_in;
      dat_s2     <= dat_s1;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (state == ST_IDLE) begin
        cnt <= '0;
        if (fall && !dat_s2) begin
          state   <= ST_DATA;
          bit_cnt <= '0;
        end
      end else if (fall) begin
        cnt <= '0;
        case (state)
          ST_DATA: begin
            shift   <= {dat_s2, shift[BYTE_W-1:1]};
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == BIT_CNT_W'(BYTE_W - 1)) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par   <= dat_s2;
            state <= ST_STOP;
          end
          ST_STOP: begin
            if (dat_s2 && odd_parity_ok(shift, par)) begin
              byte_data  <= shift;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (cnt == CNT_LAST) begin
        // Clock stalled mid-frame: drop the partial byte.
        cnt       <= cnt + CNT_W'(1);
        state     <= ST_IDLE;
        frame_err <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_paddle_keys.sv
// PS/2 keyboard to paddle controls: decodes E0/F0 prefixes and turns the
// UP/DOWN make/break codes into held levels.
//   clock, reset_n          : 50 MHz system clock, async active-low reset
//   ps2_clk_in, ps2_dat_in  : raw asynchronous PS/2 pins
//   up, down                : held key levels
//   scan_code, scan_valid   : last non-prefix byte and its update strobe
//   frame_err               : one-cycle strobe on a bad or timed-out frame
module ps2_paddle_keys
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  UP_CODE        = PS2_UP_DEF,
  parameter logic [7:0]  DOWN_CODE      = PS2_DOWN_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ps2_clk_in,
  input  logic              ps2_dat_in,
  output logic              up,
  output logic              down,
  output logic [BYTE_W-1:0] scan_code,
  output logic              scan_valid,
  output logic              frame_err
);

  logic [BYTE_W-1:0] byte_data;
  logic              byte_valid;
  logic              rx_err;
  logic              ext;
  logic              brk;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clock     (clock),
    .reset_n   (reset_n),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (rx_err)
  );

  // Prefix decoder; ext is kept for debug only so arrow and keypad keys match alike.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      up         <= 1'b0;
      down       <= 1'b0;
      scan_code  <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      ext        <= 1'b0;
      brk        <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= rx_err;
      if (byte_valid) begin
        if (byte_data == PS2_EXT) begin
          ext <= 1'b1;
        end else if (byte_data == PS2_BRK) begin
          brk <= 1'b1;
        end else begin
          scan_code  <= byte_data;
          scan_valid <= 1'b1;
          if (byte_data == UP_CODE)   up   <= ~brk;
          if (byte_data == DOWN_CODE) down <= ~brk;
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end

endmodule
